bitcount_arb: RTL



---
 rtl/bitcount_arb_pkg.sv | 22 ++
 rtl/bitcount_arb_rr_pick.sv | 40 ++++
 rtl/bitcount_arb.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bitcount_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : bitcount_pkg
// Purpose : Shared state encoding and default sizing for the bit-count arbiter.
// Rev     : 1.0
// ============================================================================
package bitcount_pkg;

    localparam int DEFAULT_N = 8;
    localparam int DEFAULT_K = 4;
    localparam int DEFAULT_M = 4;
    localparam int ID_W      = $clog2(DEFAULT_M);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bitcount_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin picker; searches upward from rr_ptr+1.
// Rev     : 1.0
// ============================================================================
module rr_pick
    import bitcount_pkg::*;
#(
    parameter int M     = DEFAULT_M,
    parameter int IDX_W = $clog2(M)
) (
    input  logic [M-1:0]     i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [M-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    // Walk from lowest to highest priority; the last hit written wins.
    always_comb begin
        o_gnt      = '0;
        o_idx      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int i = M; i >= 1; i--) begin
            w_cand     = (int'(i_rr_ptr) + i) % M;
            w_cand_idx = w_cand[IDX_W-1:0];
            if (i_req[w_cand_idx]) begin
                o_gnt             = '0;
                o_gnt[w_cand_idx] = 1'b1;
                o_idx             = w_cand_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bitcount_arb.sv
`default_nettype none
// ============================================================================
// Module  : bitcount_arb
// Purpose : Round-robin sequencer sharing one bit-count engine between M
//           requesters. Optional engine watchdog: BITCOUNT_ARB_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
module bitcount_arb
    import bitcount_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int K       = DEFAULT_K,
    parameter int M       = DEFAULT_M,
    parameter int TMO_CYC = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [M-1:0]         req,
    input  logic [M*N-1:0]       req_data,
    output logic [M-1:0]         ack,
    output logic [K-1:0]         rsp_cnt,
    output logic [$clog2(M)-1:0] rsp_id,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 eng_start,
    output logic [N-1:0]         eng_a,
    input  logic                 eng_done,
    input  logic [K-1:0]         eng_cnt
);

    localparam int c_ID_W = $clog2(M);

    state_t              r_state_q,     w_state_d;
    logic [c_ID_W-1:0]   r_gidx_q,      w_gidx_d;
    logic [c_ID_W-1:0]   r_rr_ptr_q,    w_rr_ptr_d;
    logic [M-1:0]        r_ack_q,       w_ack_d;
    logic [K-1:0]        r_rsp_cnt_q,   w_rsp_cnt_d;
    logic [c_ID_W-1:0]   r_rsp_id_q,    w_rsp_id_d;
    logic                r_rsp_err_q,   w_rsp_err_d;
    logic                r_busy_q,      w_busy_d;
    logic                r_eng_start_q, w_eng_start_d;
    logic [N-1:0]        r_eng_a_q,     w_eng_a_d;

    logic [M-1:0]        w_pick_gnt;
    logic [c_ID_W-1:0]   w_pick_idx;

`ifdef BITCOUNT_ARB_TIMEOUT_EN
    localparam int                c_TMO_W    = $clog2(TMO_CYC + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TMO_CYC - 1);
    logic [c_TMO_W-1:0]           r_tmo_q, w_tmo_d;
`endif

    rr_pick #(
        .M     (M),
        .IDX_W (c_ID_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr_q),
        .o_gnt    (w_pick_gnt),
        .o_idx    (w_pick_idx)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_gidx_d      = r_gidx_q;
        w_rr_ptr_d    = r_rr_ptr_q;
        w_ack_d       = '0;
        w_rsp_cnt_d   = r_rsp_cnt_q;
        w_rsp_id_d    = r_rsp_id_q;
        w_rsp_err_d   = r_rsp_err_q;
        w_eng_start_d = 1'b0;
        w_eng_a_d     = r_eng_a_q;
`ifdef BITCOUNT_ARB_TIMEOUT_EN
        w_tmo_d       = r_tmo_q;
`endif
        // Outputs are registered, so each is set on the transition into
        // the state where it must be visible.
        case (r_state_q)
            IDLE: begin
                if (|w_pick_gnt) begin
                    w_gidx_d      = w_pick_idx;
                    w_eng_a_d     = req_data[w_pick_idx*N +: N];
                    w_eng_start_d = 1'b1;
                    w_state_d     = ISSUE;
                end
            end
            ISSUE: begin
                w_state_d = WAIT;
`ifdef BITCOUNT_ARB_TIMEOUT_EN
                w_tmo_d   = '0;
`endif
            end
            WAIT: begin
                if (eng_done) begin
                    w_rsp_cnt_d       = eng_cnt;
                    w_rsp_err_d       = 1'b0;
                    w_rsp_id_d        = r_gidx_q;
                    w_ack_d[r_gidx_q] = 1'b1;
                    w_state_d         = RESP;
                end
`ifdef BITCOUNT_ARB_TIMEOUT_EN
                else if (r_tmo_q == c_TMO_LAST) begin
                    w_rsp_cnt_d       = '0;
                    w_rsp_err_d       = 1'b1;
                    w_rsp_id_d        = r_gidx_q;
                    w_ack_d[r_gidx_q] = 1'b1;
                    w_state_d         = RESP;
                end else begin
                    w_tmo_d = r_tmo_q + 1'b1;
                end
`endif
            end
            RESP: begin
                w_rr_ptr_d = r_gidx_q;
                w_state_d  = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
        w_busy_d = (w_state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_gidx_q      <= '0;
            r_rr_ptr_q    <= c_ID_W'(M - 1);
            r_ack_q       <= '0;
            r_rsp_cnt_q   <= '0;
            r_rsp_id_q    <= '0;
            r_rsp_err_q   <= 1'b0;
            r_busy_q      <= 1'b0;
            r_eng_start_q <= 1'b0;
            r_eng_a_q     <= '0;
`ifdef BITCOUNT_ARB_TIMEOUT_EN
            r_tmo_q       <= '0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_gidx_q      <= w_gidx_d;
            r_rr_ptr_q    <= w_rr_ptr_d;
            r_ack_q       <= w_ack_d;
            r_rsp_cnt_q   <= w_rsp_cnt_d;
            r_rsp_id_q    <= w_rsp_id_d;
            r_rsp_err_q   <= w_rsp_err_d;
            r_busy_q      <= w_busy_d;
            r_eng_start_q <= w_eng_start_d;
            r_eng_a_q     <= w_eng_a_d;
`ifdef BITCOUNT_ARB_TIMEOUT_EN
            r_tmo_q       <= w_tmo_d;
`endif
        end
    end

    assign ack       = r_ack_q;
    assign rsp_cnt   = r_rsp_cnt_q;
    assign rsp_id    = r_rsp_id_q;
    assign rsp_err   = r_rsp_err_q;
    assign busy      = r_busy_q;
    assign eng_start = r_eng_start_q;
    assign eng_a     = r_eng_a_q;

endmodule
`default_nettype wire
